exec_int_wb: RTL

// Issue/writeback tracker wrapped around the integer execute unit. Accepts int ops from decode, drives the

---
 rtl/exec_int_wb_if.sv | 41 ++++
 rtl/exec_int_wb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/exec_int_wb_if.sv
// Bundle of issue, execute-unit and writeback signals around the integer execute tracker.
// The slave modport is the tracker's view; the master modport is the decode/execute/regfile side.
interface exec_int_wb_if #(
  parameter int XLEN = 64,
  parameter int ALEN = 64
);
  logic            issue_valid;
  logic            issue_ready;
  logic [4:0]      issue_rd;
  logic [ALEN-1:0] issue_addr;
  logic            issue_is_muldiv;
  logic            flush;
  logic            exec_input_valid;
  logic            exec_int_output_valid;
  logic            exec_int_exception;
  logic [3:0]      exec_int_trap_cause;
  logic [XLEN-1:0] exec_int_result;
  logic            pending_valid;
  logic [4:0]      pending_rd;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            trap_valid;
  logic [3:0]      trap_cause;
  logic [ALEN-1:0] trap_addr;
  logic            wdog_timeout;

  modport slave (
    input  issue_valid, issue_rd, issue_addr, issue_is_muldiv, flush,
    input  exec_int_output_valid, exec_int_exception, exec_int_trap_cause, exec_int_result,
    output issue_ready, exec_input_valid, pending_valid, pending_rd,
    output rf_we, rf_waddr, rf_wdata, trap_valid, trap_cause, trap_addr, wdog_timeout
  );

  modport master (
    output issue_valid, issue_rd, issue_addr, issue_is_muldiv, flush,
    output exec_int_output_valid, exec_int_exception, exec_int_trap_cause, exec_int_result,
    input  issue_ready, exec_input_valid, pending_valid, pending_rd,
    input  rf_we, rf_waddr, rf_wdata, trap_valid, trap_cause, trap_addr, wdog_timeout
  );
endinterface

// File: rtl/exec_int_wb.sv
// Issue/writeback tracker for the integer execute unit: one op in flight, mul/div blocking,
// flush draining of killed mul/div ops and a watchdog on long-running multi-cycle ops.
module exec_int_wb #(
  parameter int XLEN     = 64,
  parameter int ALEN     = 64,
  parameter int WDOG_MAX = 127
) (
  input  logic         clk,
  input  logic         rst,
  exec_int_wb_if.slave bus
);
  localparam int CW = $clog2(WDOG_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SINGLE = 2'd1;
  localparam logic [1:0] S_MULTI  = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [ALEN-1:0] addr_q, addr_d;
  logic [CW-1:0]   wdog_q, wdog_d;

  logic            done_s, base_rdy_s, ready_s, accept_s, busy_s;
  logic            wb_s, wr_s, trap_s, at_max_s, timeout_s;
  logic [XLEN-1:0] wdata_s;

  // Handshake, writeback qualification and watchdog expiry for the current cycle.
  always_comb begin
    done_s = bus.exec_int_output_valid;
    case (state_q)
      S_IDLE, S_SINGLE: base_rdy_s = 1'b1;
      S_MULTI:          base_rdy_s = done_s;
      default:          base_rdy_s = 1'b0;
    endcase
    ready_s   = base_rdy_s & ~bus.flush & rst;
    accept_s  = bus.issue_valid & ready_s;
    busy_s    = (state_q == S_SINGLE) || (state_q == S_MULTI);
    wb_s      = busy_s & done_s & ~bus.flush & rst;
    trap_s    = wb_s & bus.exec_int_exception;
    wr_s      = wb_s & ~bus.exec_int_exception & (rd_q != 5'd0);
    at_max_s  = (wdog_q == CW'(WDOG_MAX));
    // A flush out of MULTI restarts the count in DRAIN, so it must not also time out.
    timeout_s = rst & at_max_s & ~done_s &
                (((state_q == S_MULTI) & ~bus.flush) | (state_q == S_DRAIN));
  end

  // Next-state, op-tracking and watchdog-count logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_SINGLE: state_d = S_IDLE;
      S_MULTI: begin
        if (bus.flush) begin
          state_d = done_s ? S_IDLE : S_DRAIN;
        end else if (done_s || timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MULTI;
        end
      end
      S_DRAIN: begin
        if (done_s || timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept_s) begin
      state_d = bus.issue_is_muldiv ? S_MULTI : S_SINGLE;
      rd_d    = bus.issue_rd;
      addr_d  = bus.issue_addr;
    end else begin
      rd_d    = rd_q;
      addr_d  = addr_q;
    end

    if (accept_s || (state_d != state_q)) begin
      wdog_d = {CW{1'b0}};
    end else if (!at_max_s && ((state_q == S_MULTI) || (state_q == S_DRAIN))) begin
      wdog_d = wdog_q + CW'(1);
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Writeback data is zeroed outside a register write to keep the bus quiet.
  always_comb begin
    wdata_s = wr_s ? bus.exec_int_result : {XLEN{1'b0}};
  end

  // Drive the interface outputs.
  always_comb begin
    bus.issue_ready      = ready_s;
    bus.exec_input_valid = accept_s;
    bus.pending_valid    = busy_s & rst;
    bus.pending_rd       = (busy_s & rst) ? rd_q : 5'd0;
    bus.rf_we            = wr_s;
    bus.rf_waddr         = wr_s ? rd_q : 5'd0;
    bus.rf_wdata         = wdata_s;
    bus.trap_valid       = trap_s;
    bus.trap_cause       = trap_s ? bus.exec_int_trap_cause : 4'd0;
    bus.trap_addr        = trap_s ? addr_q : {ALEN{1'b0}};
    bus.wdog_timeout     = timeout_s;
  end

  // State and op registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rd_q    <= 5'd0;
      addr_q  <= {ALEN{1'b0}};
      wdog_q  <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdog_q  <= wdog_d;
    end
  end
endmodule
